sync_debounce_bank: RTL
=======================

SYNC_DEBOUNCE_BANK -- requirements
Module: sync_debounce_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 6, number of independent input channels (legal: >=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per channel (legal: >=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before a level change (legal: >=1).
REQ-004 SHALL have parameter RESET_LEVEL, default all-zero, CHANNELS-bit value loaded into sync chain and filtered level on reset.
REQ-005 SHALL have port clk_i  input  1  single clock; every flop is on its rising edge.
REQ-006 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_i  input  CHANNELS  asynchronous raw pin inputs.
REQ-008 SHALL have port en_i  input  CHANNELS  per-channel filter enable, synchronous to clk_i.
REQ-009 SHALL have port level_o  output  CHANNELS  registered, synchronized, debounced level.
REQ-010 SHALL have port rise_o  output  CHANNELS  registered one-cycle pulse on level_o 0->1.
REQ-011 SHALL have port fall_o  output  CHANNELS  registered one-cycle pulse on level_o 1->0.

Function
REQ-012 Each channel SHALL pass in_i through a SYNC_STAGES-deep flop chain; chain output is "s".
REQ-013 Per channel: s == level_o -> counter cleared to 0 next cycle.
REQ-014 Per channel: s != level_o and counter < DEBOUNCE_CYCLES-1 -> counter increments.
REQ-015 Per channel: s != level_o and counter == DEBOUNCE_CYCLES-1 -> level_o takes s, counter clears, same edge.
REQ-016 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).
REQ-017 Latency: input change sampled at edge 0 and held stable SHALL appear on level_o at edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-018 Any reversion of s to level_o before the terminal count SHALL discard the pending change (glitch rejected, no pulse).
REQ-019 DEBOUNCE_CYCLES=1: level_o SHALL follow s with exactly one cycle delay.
REQ-020 rise_o/fall_o SHALL be high exactly in the first cycle level_o shows its new value, and low otherwise.
REQ-021 en_i[k]=0: counter[k] held at 0, level_o[k] frozen, rise_o[k]/fall_o[k] forced 0; sync chain keeps shifting.
REQ-022 en_i[k] 0->1 with s != level_o: counting SHALL start from 0 (full DEBOUNCE_CYCLES required).
REQ-023 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-024 While reset_i=1 at a clock edge: sync chains and level_o load RESET_LEVEL, counters 0, rise_o=0, fall_o=0.
REQ-025 Reset mid-debounce SHALL discard the pending change; no pulse SHALL be generated from the reset transition itself.
REQ-026 en_i SHALL have no effect while reset_i=1.

Configuration
REQ-027 Macro SYNC_DEBOUNCE_BANK_DEBOUNCE_EN defined: debounce counters per REQ-013..REQ-022.
REQ-028 Macro undefined: no counters instantiated; DEBOUNCE_CYCLES ignored; behaviour identical to DEBOUNCE_CYCLES=1 (REQ-019), en_i still freezes level_o and suppresses pulses.

Structure
REQ-029 Shared package SHALL hold default CHANNELS, SYNC_STAGES, DEBOUNCE_CYCLES and a counter-width function.
REQ-030 One sub-module sync_debounce_channel (single-bit sync chain + counter + edge pulses) SHALL be generated CHANNELS times.

Verification (CHANNELS=6, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, macro defined unless stated)
REQ-031 reset_i=1 two cycles with in_i=6'h3F -> level_o=6'h00, rise_o=fall_o=0 throughout; after release level_o[5:0] rise at edge 6.
REQ-032 in_i[0] 0->1 held -> level_o[0]=1 at edge 6, rise_o[0]=1 for that single cycle only; then in_i[0]->0 held -> fall_o[0] pulse 6 edges later.
REQ-033 in_i[1] high for 3 cycles then low -> level_o[1], rise_o[1] stay 0.
REQ-034 en_i[2]=0, in_i[2] high 10 cycles -> level_o[2]=0; en_i[2]->1 -> level_o[2]=1 exactly 4 edges later.
REQ-035 in_i[3] high, reset_i pulsed at edge 4 -> level_o[3]=0, no pulse; rises 6 edges after reset release.
REQ-036 Macro undefined, in_i[4] 0->1 -> level_o[4]=1 at edge 3 with rise_o[4] pulse; 1-cycle glitch passes through.

Source files
------------

// File: rtl/sync_debounce_bank_pkg.sv
// Shared defaults and helpers for the synchronizing debounce bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_debounce_bank_pkg;

    localparam int DEF_CHANNELS        = 6;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Width of a counter that must hold values 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel: SYNC_STAGES-deep synchronizer, optional stability counter, edge pulses.
// Latency: a held input change shows on level_o SYNC_STAGES+DEBOUNCE_CYCLES edges after it is first sampled.
// Backpressure: none; en_i=0 freezes level_o, holds the counter at 0 and suppresses pulses.
// Ports: clk_i, reset_i (sync, active-high), in_i (async pin), en_i (filter enable),
//        level_o (debounced level), rise_o / fall_o (one-cycle edge pulses).
// Macro SYNC_DEBOUNCE_BANK_DEBOUNCE_EN enables the counter; otherwise level_o follows s one cycle later.
module sync_debounce_channel
    import sync_debounce_bank_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
`ifdef SYNC_DEBOUNCE_BANK_DEBOUNCE_EN
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`endif
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic in_i,
    input  logic en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
    assign s      = sync_q[SYNC_STAGES-1];

`ifdef SYNC_DEBOUNCE_BANK_DEBOUNCE_EN
    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only ever runs while s disagrees with level_q; any agreement
    // (or a disabled channel) clears it, so a glitch shorter than the terminal
    // count never reaches level_q.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en_i && (s != level_q)) begin
            if (cnt_q == TERM) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en_i && (s != level_q)) begin
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= {SYNC_STAGES{RESET_BIT}};
            level_q <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of CHANNELS independent synchronize-and-debounce channels with edge pulses.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges from first sample to level_o (SYNC_STAGES+1 without debounce).
// Backpressure: none; en_i[k]=0 freezes channel k's level and suppresses its pulses.
// Ports: clk_i, reset_i (sync, active-high), in_i[CHANNELS] (async pins), en_i[CHANNELS],
//        level_o / rise_o / fall_o [CHANNELS] (all registered).
// Macro SYNC_DEBOUNCE_BANK_DEBOUNCE_EN enables the per-channel stability counters.
module sync_debounce_bank
    import sync_debounce_bank_pkg::*;
#(
    parameter int                  CHANNELS        = DEF_CHANNELS,
    parameter int                  SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0] RESET_LEVEL     = '0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [CHANNELS-1:0] in_i,
    input  logic [CHANNELS-1:0] en_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        sync_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
`ifdef SYNC_DEBOUNCE_BANK_DEBOUNCE_EN
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`endif
            .RESET_BIT       (RESET_LEVEL[k])
        ) u_ch (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .in_i    (in_i[k]),
            .en_i    (en_i[k]),
            .level_o (level_o[k]),
            .rise_o  (rise_o[k]),
            .fall_o  (fall_o[k])
        );
    end

endmodule
